uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//  Upstream of the CPU core. Receives a program image over a UART line and
//  writes it into the shared 256x8 RAM from address 0 upward. Then asserts
//  cpu_run, which gates the CPU state machine so execution starts at pc=0.
//  While loading, the loader owns the RAM write port and the CPU is held idle.
// PARAMETERS
//  CLKS_PER_BIT  104  clk cycles per UART bit (12 MHz / 115200 baud)
//  ADDR_W        8    RAM address width; image length is 1..2**ADDR_W bytes
// PORTS
//  clk        in   1       system clock (12 MHz); every register is on posedge clk
//  rst        in   1       reset: synchronous, active-high
//  rx         in   1       UART RX line, async, idle high, 8N1, LSB first
//  mem_we     out  1       RAM write enable, one-cycle pulse per byte
//  mem_addr   out  ADDR_W  RAM write address
//  mem_wdata  out  8       RAM write data
//  cpu_run    out  1       high = CPU may execute; stays high until rst
//  busy       out  1       high from length byte accepted until image complete
//  err        out  1       sticky: framing error, or checksum mismatch with CHECKSUM_EN
// BEHAVIOUR
//  Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, busy=0, err=0.
//   Both FSMs return to idle. The bit counter and byte counter clear.
//  A rst during a load aborts it. RAM contents already written stay as they are.
//  rx passes through a 2-FF synchroniser first, which adds 2 cycles of latency.
//  RX FSM:
//   - RX_IDLE: wait for a synchronised high-to-low edge -> RX_START.
//   - RX_START: at CLKS_PER_BIT/2, rx still low -> RX_DATA; rx high -> glitch,
//     back to RX_IDLE with no error.
//   - RX_DATA: sample every CLKS_PER_BIT, 8 bits, LSB first -> RX_STOP.
//   - RX_STOP: sample once. If high, pulse rx_valid for 1 cycle with the byte.
//     If low, framing error: set err, drop the byte, and the loader FSM goes
//     back to L_LEN. Then RX_IDLE.
//  Loader FSM (advances only on rx_valid):
//   - L_LEN: byte is N; N=0 means 2**ADDR_W. Load count=N, busy=1,
//     addr=0 -> L_DATA. Accepting a length byte clears err.
//   - L_DATA: on the cycle after rx_valid, mem_we=1, mem_addr=addr,
//     mem_wdata=byte; then addr increments and count decrements.
//     When count reaches 0 -> L_DONE (or L_SUM if checksum is enabled).
//   - L_DONE: busy=0, cpu_run=1, starting on the cycle after the last mem_we.
//     This state is terminal: rx is ignored until rst.
//  mem_addr wraps modulo 2**ADDR_W. With N=0 the last write goes to 8'hFF.
//  mem_we is never high for two consecutive cycles.
//  mem_we and cpu_run are never both high in the same cycle.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//   - After the N data bytes, one extra byte S is received in state L_SUM.
//   - The 8-bit sum of all data bytes plus S must be 8'h00.
//   - Match -> L_DONE. Mismatch -> err=1, busy=0, back to L_LEN, cpu_run stays 0.
//   - The data bytes have already been written to RAM either way.
//  LOADER_CHECKSUM_EN undefined:
//   - There is no L_SUM state; cpu_run rises right after the last data byte.
// TESTING
//  1. Send 03,01,05,07 at 115200 baud -> writes (0,01),(1,05),(2,07);
//     cpu_run rises 1 cycle after the 3rd mem_we; busy falls in the same cycle.
//  2. Send 00 followed by 256 bytes 00..FF -> 256 writes, last one addr=FF data=FF;
//     cpu_run=1; mem_addr wraps back to 00.
//  3. A low pulse on rx shorter than CLKS_PER_BIT/2 -> no rx_valid, err=0, state unchanged.
//  4. Byte with stop bit forced low during L_DATA -> err=1, no mem_we for it,
//     next byte is taken as a length byte; a clean 01,AA then loads (0,AA) and clears err.
//  5. rst pulse after 2 of 4 data bytes -> all outputs at reset values next cycle;
//     a new image 01,3C loads at addr 0.
//  6. LOADER_CHECKSUM_EN: 02,10,20,D0 -> cpu_run=1;
//     02,10,20,D1 -> err=1, cpu_run=0, back in L_LEN.

Source files
------------

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART 8N1 receiver that loads a length-prefixed image into RAM from address 0, then releases the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte (data sum + S == 0) before cpu_run.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NW = ADDR_W + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE, L_SUM} ld_t;
  localparam ld_t L_END = L_SUM;
`else
  typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE} ld_t;
  localparam ld_t L_END = L_DONE;
`endif
  rx_t r_state, r_next;
  ld_t l_state, l_next;
  logic rx_m, rx_s, rx_d;
  logic [CW-1:0] clk_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift, sum, sum_chk;
  logic [NW-1:0] cnt;
  logic half, full, rx_valid, frame_err, take_len, take_data, last_we;
  assign half = clk_cnt == HALF;
  assign full = clk_cnt == FULL;
  assign rx_valid = r_state == RX_STOP && full && rx_s;
  // Once the image is complete the line is ignored, so late framing errors must not raise err.
  assign frame_err = r_state == RX_STOP && full && !rx_s && l_state != L_DONE;
  assign take_len = rx_valid && l_state == L_LEN;
  assign take_data = rx_valid && l_state == L_DATA;
  assign last_we = mem_we && cnt == NW'(1);
  assign sum_chk = sum + shift;
  assign cpu_run = l_state == L_DONE;
`ifdef LOADER_CHECKSUM_EN
  assign busy = l_state == L_DATA || l_state == L_SUM;
`else
  assign busy = l_state == L_DATA;
`endif
  always_ff @(posedge clk) begin
    if (rst) {rx_m, rx_s, rx_d} <= 3'b111;
    else {rx_m, rx_s, rx_d} <= {rx, rx_m, rx_s};
  end
  always_comb begin
    r_next = r_state;
    case (r_state)
      RX_IDLE:  r_next = (rx_d && !rx_s) ? RX_START : RX_IDLE;
      RX_START: r_next = !half ? RX_START : rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  r_next = (full && bit_cnt == 3'd7) ? RX_STOP : RX_DATA;
      default:  r_next = full ? RX_IDLE : RX_STOP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RX_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
    end else begin
      r_state <= r_next;
      clk_cnt <= (r_next != r_state || r_state == RX_IDLE || full) ? '0 : clk_cnt + CW'(1);
      if (r_state == RX_START) bit_cnt <= '0;
      if (r_state == RX_DATA && full) begin
        shift <= {rx_s, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end
  always_comb begin
    l_next = l_state;
    if (frame_err) l_next = L_LEN;
    else
      case (l_state)
        L_LEN:  l_next = rx_valid ? L_DATA : L_LEN;
        L_DATA: l_next = last_we ? L_END : L_DATA;
`ifdef LOADER_CHECKSUM_EN
        L_SUM:  l_next = !rx_valid ? L_SUM : sum_chk == 8'h00 ? L_DONE : L_LEN;
`endif
        default: l_next = l_state;
      endcase
  end
  // mem_addr is the write pointer itself: it advances in the cycle after each write pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_state <= L_LEN;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cnt <= '0;
      sum <= '0;
      err <= 1'b0;
    end else begin
      l_state <= l_next;
      mem_we <= take_data;
      if (take_data) begin
        mem_wdata <= shift;
        sum <= sum_chk;
      end
      if (mem_we) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        cnt <= cnt - NW'(1);
      end
      if (take_len) begin
        cnt <= shift == 8'h00 ? NW'(1 << ADDR_W) : NW'(shift);
        mem_addr <= '0;
        sum <= '0;
        err <= 1'b0;
      end
      if (frame_err) err <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if (rx_valid && l_state == L_SUM && sum_chk != 8'h00) err <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed UART images with a write scoreboard checked by a negedge monitor.
module tb_uart_prog_loader;
  localparam int CPB = 16;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic mem_we, cpu_run, busy, err;
  logic [7:0] mem_addr, mem_wdata;
  int vecs = 0, errs = 0, cyc = 0, last_we_cyc = -10, rise_cyc = -1;
  logic busy_at_rise = 1'b1, prev_we = 1'b0, prev_run = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] e;
  logic [7:0] s;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .rx(rx), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_we: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("we_addr", mem_addr, e[15:8]);
          chk("we_data", mem_wdata, e[7:0]);
        end
        chk("we_gap", prev_we, 0);
        chk("we_vs_run", cpu_run, 0);
        last_we_cyc = cyc;
      end
      if (cpu_run && !prev_run) begin
        rise_cyc = cyc;
        busy_at_rise = busy;
      end
    end
    prev_we = mem_we;
    prev_run = cpu_run;
  end

  initial begin
    repeat (100000) @(negedge clk);
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_w(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic finish_img(input logic [7:0] data_sum);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00 - data_sum);
`endif
  endtask

  task automatic wait_run(input string name);
    for (int i = 0; i < 40 * CPB && !cpu_run; i++) @(negedge clk);
    chk(name, cpu_run, 1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", {mem_we, mem_addr, mem_wdata, cpu_run, busy, err}, 0);
    rst = 1'b0;
    @(negedge clk);
    // basic three-byte image
    expect_w(8'h00, 8'h01); expect_w(8'h01, 8'h05); expect_w(8'h02, 8'h07);
    send_byte(8'h03);
    chk("t1_busy", busy, 1);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h07);
    finish_img(8'h0D);
    wait_run("t1_run");
`ifndef LOADER_CHECKSUM_EN
    chk("t1_run_latency", rise_cyc - last_we_cyc, 1);
    chk("t1_busy_at_rise", busy_at_rise, 0);
`endif
    chk("t1_addr", mem_addr, 3);
    send_byte(8'h55);
    chk("t1_terminal", {cpu_run, busy, err}, 3'b100);
    // N=0 means a full 256-byte image
    reset_dut();
    send_byte(8'h00);
    s = 8'h00;
    for (int i = 0; i < 256; i++) begin
      expect_w(8'(i), 8'(i));
      send_byte(8'(i));
      s = s + 8'(i);
    end
    finish_img(s);
    wait_run("t2_run");
    chk("t2_addr_wrap", mem_addr, 0);
    chk("t2_all_written", exp_q.size(), 0);
    // short glitch mid-load is ignored
    reset_dut();
    send_byte(8'h02);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("t3_err", err, 0);
    chk("t3_busy", busy, 1);
    expect_w(8'h00, 8'h11); expect_w(8'h01, 8'h22);
    send_byte(8'h11); send_byte(8'h22);
    finish_img(8'h33);
    wait_run("t3_run");
    // framing error drops the byte and returns to length
    reset_dut();
    send_byte(8'h02);
    expect_w(8'h00, 8'h33);
    send_byte(8'h33);
    send_byte(8'h44, 1'b0);
    chk("t4_err_set", err, 1);
    chk("t4_busy", busy, 0);
    send_byte(8'h01);
    chk("t4_err_clr", err, 0);
    expect_w(8'h00, 8'hAA);
    send_byte(8'hAA);
    finish_img(8'hAA);
    wait_run("t4_run");
    chk("t4_all_written", exp_q.size(), 0);
    // reset mid-image aborts
    reset_dut();
    send_byte(8'h04);
    expect_w(8'h00, 8'h01); expect_w(8'h01, 8'h02);
    send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_reset_outs", {mem_we, mem_addr, mem_wdata, cpu_run, busy, err}, 0);
    rst = 1'b0;
    chk("t5_written", exp_q.size(), 0);
    expect_w(8'h00, 8'h3C);
    send_byte(8'h01); send_byte(8'h3C);
    finish_img(8'h3C);
    wait_run("t5_run");
`ifdef LOADER_CHECKSUM_EN
    reset_dut();
    expect_w(8'h00, 8'h10); expect_w(8'h01, 8'h20);
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'hD0);
    wait_run("t6_run_good");
    reset_dut();
    expect_w(8'h00, 8'h10); expect_w(8'h01, 8'h20);
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'hD1);
    chk("t6_bad_sum", {cpu_run, busy, err}, 3'b001);
    expect_w(8'h00, 8'hAA);
    send_byte(8'h01); send_byte(8'hAA); send_byte(8'h56);
    wait_run("t6_reload_run");
    chk("t6_err_clr", err, 0);
`endif
    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
